// File: rtl/ad1939_dac_serializer.sv
// AD1939 DAC-port I2S serializer: BCLK/LRCLK from MCLK, one-deep holding buffer per channel.
// Pins are flops decoded from next-state; a sample accepted before a frame load is sent in that frame.
module ad1939_dac_serializer #(
  parameter int DATA_W    = 24,
  parameter int SLOT_W    = 32,
  parameter int BCLK_DIV  = 4,
  parameter int I2S_DELAY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] left_data,
  input  logic              left_valid,
  output logic              left_ready,
  input  logic [DATA_W-1:0] right_data,
  input  logic              right_valid,
  output logic              right_ready,
  output logic              dac_bclk,
  output logic              dac_lrclk,
  output logic              dac_sdata,
  output logic              frame_start,
  output logic              underrun
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_W);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              lfull_q, lfull_d, rfull_q, rfull_d;
  logic [DATA_W-1:0] lbuf_q, lbuf_d, rbuf_q, rbuf_d;
  logic [DATA_W-1:0] lframe_q, lframe_d, rframe_q, rframe_d;
  logic              first_q, first_d;
  logic              bclk_q, bclk_d;
  logic              lrclk_q, lrclk_d;
  logic              sdata_q, sdata_d;
  logic              fs_q, fs_d;
  logic              ur_q, ur_d;

  logic              div_wrap;
  logic              load;
  logic              l_xfer, r_xfer;
  logic [DATA_W-1:0] word;
  int                pos;
  logic [IDX_W-1:0]  idx;

  assign div_wrap = (div_q == DIV_W'(BCLK_DIV - 1));
  assign load     = div_wrap && (bit_q == BIT_W'(2 * SLOT_W - 1));
  assign l_xfer   = left_valid  && !lfull_q;
  assign r_xfer   = right_valid && !rfull_q;

  always_comb begin
    div_d = div_wrap ? '0 : div_q + 1'b1;
    bit_d = bit_q;
    if (div_wrap) begin
      bit_d = (bit_q == BIT_W'(2 * SLOT_W - 1)) ? '0 : bit_q + 1'b1;
    end

    // A load empties both buffers; a same-cycle transfer into an empty buffer survives for the next frame.
    lfull_d  = load ? l_xfer : (lfull_q | l_xfer);
    rfull_d  = load ? r_xfer : (rfull_q | r_xfer);
    lbuf_d   = l_xfer ? left_data  : lbuf_q;
    rbuf_d   = r_xfer ? right_data : rbuf_q;
    lframe_d = lframe_q;
    rframe_d = rframe_q;
    if (load) begin
      lframe_d = lfull_q ? lbuf_q : '0;
      rframe_d = rfull_q ? rbuf_q : '0;
    end
    first_d = load ? 1'b0 : first_q;
    fs_d    = load;
    ur_d    = load && (!lfull_q || !rfull_q) && !first_q;
  end

  // Pin decode runs on next-state so each pin flop shows this cycle's slot position.
  always_comb begin
    bclk_d  = (div_d >= DIV_W'(BCLK_DIV / 2));
    lrclk_d = (bit_d >= BIT_W'(SLOT_W));
    word    = lrclk_d ? rframe_d : lframe_d;
    pos     = lrclk_d ? int'(bit_d) - SLOT_W : int'(bit_d);
    idx     = '0;
    sdata_d = 1'b0;
    if (pos >= I2S_DELAY && pos < I2S_DELAY + DATA_W) begin
      idx     = IDX_W'(DATA_W - 1 - (pos - I2S_DELAY));
      sdata_d = word[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      bit_q    <= '0;
      lfull_q  <= 1'b0;
      rfull_q  <= 1'b0;
      lbuf_q   <= '0;
      rbuf_q   <= '0;
      lframe_q <= '0;
      rframe_q <= '0;
      first_q  <= 1'b1;
      bclk_q   <= 1'b0;
      lrclk_q  <= 1'b0;
      sdata_q  <= 1'b0;
      fs_q     <= 1'b0;
      ur_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      bit_q    <= bit_d;
      lfull_q  <= lfull_d;
      rfull_q  <= rfull_d;
      lbuf_q   <= lbuf_d;
      rbuf_q   <= rbuf_d;
      lframe_q <= lframe_d;
      rframe_q <= rframe_d;
      first_q  <= first_d;
      bclk_q   <= bclk_d;
      lrclk_q  <= lrclk_d;
      sdata_q  <= sdata_d;
      fs_q     <= fs_d;
      ur_q     <= ur_d;
    end
  end

  assign left_ready  = !lfull_q;
  assign right_ready = !rfull_q;
  assign dac_bclk    = bclk_q;
  assign dac_lrclk   = lrclk_q;
  assign dac_sdata   = sdata_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;

endmodule

// File: tb/tb_ad1939_dac_serializer.sv
// Bench for ad1939_dac_serializer: cycle-count frame model plus directed frame captures.
module tb_ad1939_dac_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] left_data, right_data;
  logic        left_valid, right_valid;
  logic        left_ready, right_ready;
  logic        dac_bclk, dac_lrclk, dac_sdata, frame_start, underrun;

  always #5 clk = ~clk;

  ad1939_dac_serializer dut (
    .clk(clk), .reset(reset),
    .left_data(left_data), .left_valid(left_valid), .left_ready(left_ready),
    .right_data(right_data), .right_valid(right_valid), .right_ready(right_ready),
    .dac_bclk(dac_bclk), .dac_lrclk(dac_lrclk), .dac_sdata(dac_sdata),
    .frame_start(frame_start), .underrun(underrun)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: mt = clock edges since reset; a frame is 256 clocks, loads on the last one.
  int          mt = 0;
  int          cyc = 0;
  bit          chk_en = 0;
  logic [23:0] lq[$], rq[$];
  logic [23:0] m_lf, m_rf;
  bit          m_first, m_fs, m_ur;
  bit          m_load, m_lacc, m_racc;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      mt = 0; lq.delete(); rq.delete();
      m_lf = 0; m_rf = 0; m_first = 1; m_fs = 0; m_ur = 0; chk_en = 1;
    end else if (chk_en) begin
      m_load = (mt % 256) == 255;
      m_lacc = left_valid && lq.size() == 0;
      m_racc = right_valid && rq.size() == 0;
      m_fs = m_load;
      m_ur = m_load && (lq.size() == 0 || rq.size() == 0) && !m_first;
      if (m_load) begin
        if (lq.size() > 0) m_lf = lq.pop_front(); else m_lf = 0;
        if (rq.size() > 0) m_rf = rq.pop_front(); else m_rf = 0;
        m_first = 0;
      end
      if (m_lacc) lq.push_back(left_data);
      if (m_racc) rq.push_back(right_data);
      mt++;
    end
  end

  always @(negedge clk) begin
    int d, b, p;
    logic [23:0] w;
    logic exp_sd;
    if (chk_en) begin
      d = mt % 4;
      b = (mt / 4) % 64;
      p = b % 32;
      w = (b < 32) ? m_lf : m_rf;
      exp_sd = (p >= 1 && p <= 24) ? w[24-p] : 1'b0;
      check("bclk", dac_bclk, d >= 2);
      check("lrclk", dac_lrclk, b >= 32);
      check("sdata", dac_sdata, exp_sd);
      check("frame_start", frame_start, m_fs);
      check("underrun", underrun, m_ur);
      check("left_ready", left_ready, lq.size() == 0);
      check("right_ready", right_ready, rq.size() == 0);
    end
  end

  // Call from posedge+#1; returns at posedge+#1 after the transfer edge.
  task automatic push(input bit ch, input logic [23:0] d);
    logic r = 1'b0;
    int n = 0;
    if (ch) begin right_data = d; right_valid = 1'b1; end
    else    begin left_data  = d; left_valid  = 1'b1; end
    while (!r && n < 600) begin
      @(negedge clk);
      r = ch ? right_ready : left_ready;
      @(posedge clk); #1;
      n++;
    end
    if (ch) right_valid = 1'b0; else left_valid = 1'b0;
    if (!r) begin
      n_chk++; n_fail++;
      $display("FAIL push_timeout: channel %0d never ready", ch);
    end
  endtask

  // Captures one frame: bits[b] = sdata sampled at BCLK rising edge of bit b.
  task automatic capture(output logic [63:0] bits, output logic ur, output logic lr_a,
                         output logic lr_b, output int at);
    int n = 0;
    bits = '0; ur = 1'b0; lr_a = 1'bx; lr_b = 1'bx; at = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 600);
    if (!frame_start) begin
      n_chk++; n_fail++;
      $display("FAIL frame_timeout: no frame_start within %0d cycles", n);
      return;
    end
    ur = underrun;
    at = cyc;
    for (int off = 1; off < 256; off++) begin
      @(negedge clk);
      if (off % 4 == 2) bits[off/4] = dac_sdata;
      if (off == 127) lr_a = dac_lrclk;
      if (off == 128) lr_b = dac_lrclk;
    end
  endtask

  function automatic logic [23:0] slot_word(input logic [63:0] bits, input int base);
    logic [23:0] w;
    for (int k = 0; k < 24; k++) w[23-k] = bits[base+1+k];
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] bits, bits2;
    logic ur, ur2, la, lb;
    int at, at_prev, n;

    reset = 1'b1; left_valid = 0; right_valid = 0; left_data = 0; right_data = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_bclk", dac_bclk, 0);
    check("rst_lrclk", dac_lrclk, 0);
    check("rst_sdata", dac_sdata, 0);
    check("rst_ready", {left_ready, right_ready}, 2'b11);
    check("rst_fs_ur", {frame_start, underrun}, 2'b00);

    // Idle: three silent frames, underrun only after the first.
    at_prev = 0;
    for (int f = 0; f < 3; f++) begin
      capture(bits, ur, la, lb, at);
      check("idle_bits", bits, 64'h0);
      check("idle_ur", ur, f != 0);
      check("idle_lr_edge", {la, lb}, 2'b01);
      if (f > 0) check("idle_period", at - at_prev, 256);
      at_prev = at;
    end

    // Stereo pair.
    @(posedge clk); #1;
    fork
      push(1'b0, 24'hA5A5A5);
      push(1'b1, 24'h5A5A5A);
    join
    capture(bits, ur, la, lb, at);
    check("stereo_left", slot_word(bits, 0), 24'hA5A5A5);
    check("stereo_right", slot_word(bits, 32), 24'h5A5A5A);
    check("stereo_left_pad", bits[31:25], 7'h0);
    check("stereo_msb_delay", bits[0], 1'b0);
    check("stereo_ur", ur, 1'b0);

    // Left only.
    @(posedge clk); #1;
    push(1'b0, 24'h800000);
    capture(bits, ur, la, lb, at);
    check("left_only_bits", bits, 64'h2);
    check("left_only_ur", ur, 1'b1);

    // Back-to-back left writes land in consecutive frames.
    @(posedge clk); #1;
    push(1'b0, 24'h123456);
    @(negedge clk);
    check("b2b_held_ready", left_ready, 1'b0);
    @(posedge clk); #1;
    fork
      push(1'b0, 24'h654321);
      begin
        capture(bits, ur, la, lb, at);
        capture(bits2, ur2, la, lb, at);
      end
    join
    check("b2b_first", slot_word(bits, 0), 24'h123456);
    check("b2b_second", slot_word(bits2, 0), 24'h654321);

    // Write on the load cycle itself: silent frame, then the sample.
    n = 0;
    do begin @(negedge clk); n++; end while ((mt % 256) != 254 && n < 600);
    @(posedge clk); #1;
    left_data = 24'h3C0F71; left_valid = 1'b1;
    @(posedge clk); #1;
    left_valid = 1'b0;
    capture(bits, ur, la, lb, at);
    capture(bits2, ur2, la, lb, at);
    check("loadcyc_first", slot_word(bits, 0), 24'h0);
    check("loadcyc_ur", ur, 1'b1);
    check("loadcyc_second", slot_word(bits2, 0), 24'h3C0F71);

    // Reset mid right slot with both buffers full.
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 600);
    @(posedge clk); #1;
    fork
      push(1'b0, 24'hDEAD01);
      push(1'b1, 24'hBEEF02);
    join
    n = 0;
    do begin @(negedge clk); n++; end while ((mt % 256) != 160 && n < 600);
    check("mid_lrclk_before", dac_lrclk, 1'b1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_pins", {dac_bclk, dac_lrclk, dac_sdata}, 3'b000);
    check("mid_rst_ready", {left_ready, right_ready}, 2'b11);
    check("mid_rst_fs_ur", {frame_start, underrun}, 2'b00);
    capture(bits, ur, la, lb, at);
    check("mid_rst_bits", bits, 64'h0);
    check("mid_rst_ur", ur, 1'b0);
    check("mid_rst_lr", {la, lb}, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
